// File: rtl/sort4_stream.sv
// Streaming 4-value insertion sorter: loads four values serially, keeping them in emit
// order as they arrive, then drains them serially with a last-flag on the fourth.
module sort4_stream #(
   parameter int unsigned WIDTH      = 4,
   parameter bit          DESCENDING = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [2:0]       count
);

   typedef enum logic {StLoad, StDrain} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s_q [4];
   logic [WIDTH-1:0] s_d [4];
   logic [2:0]       count_q, count_d;
   logic [1:0]       idx_q, idx_d;

   logic [3:0]       keep;  // entry i stays in place (it sorts before the new value)
   logic [WIDTH-1:0] ins [4];
   logic             accept;
   logic             out_hs;

   assign accept = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   // State and storage registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StLoad;
         s_q     <= '{default: '0};
         count_q <= 3'd0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state: leave LOAD on the 4th accept, leave DRAIN on the last handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (accept && count_q == 3'd3) state_d = StDrain;
         StDrain: if (out_hs && idx_q == 2'd3) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // Insertion network; equal entries are kept ahead of the new value for stability
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         keep[i] = (3'(i) < count_q) &&
                   (DESCENDING ? (s_q[i] >= in_data) : (s_q[i] <= in_data));
      end
      ins[0] = keep[0] ? s_q[0] : in_data;
      for (int i = 1; i < 4; i++) begin
         if (keep[i])        ins[i] = s_q[i];
         else if (keep[i-1]) ins[i] = in_data;
         else                ins[i] = s_q[i-1];
      end
   end

   // Storage, occupancy and drain index updates
   always_comb begin
      s_d     = s_q;
      count_d = count_q;
      idx_d   = idx_q;
      if (accept) begin
         s_d     = ins;
         count_d = count_q + 3'd1;
      end
      if (out_hs) begin
         if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            count_d = 3'd0;
         end else begin
            idx_d   = idx_q + 2'd1;
            count_d = count_q - 3'd1;
         end
      end
   end

   // Outputs decoded from registered state only (in_ready also gated by reset)
   always_comb begin
      in_ready  = (state_q == StLoad) && !rst;
      out_valid = (state_q == StDrain);
      out_data  = out_valid ? s_q[idx_q] : '0;
      out_last  = out_valid && (idx_q == 2'd3);
      count     = count_q;
   end

endmodule

// File: tb/tb_sort4_stream.sv
// Bench for sort4_stream: ascending and descending instances share all inputs; each
// group is checked against a queue-sort reference in both orders.
module tb_sort4_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_ready;

   logic       in_ready_a, out_valid_a, out_last_a;
   logic [3:0] out_data_a;
   logic [2:0] count_a;
   logic       in_ready_d, out_valid_d, out_last_d;
   logic [3:0] out_data_d;
   logic [2:0] count_d;

   int checks = 0;
   int errors = 0;

   logic [3:0] grp [4];
   int         q_asc[$];
   int         q_desc[$];

   sort4_stream #(.WIDTH(4), .DESCENDING(1'b0)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a),
      .out_ready(out_ready), .count(count_a)
   );

   sort4_stream #(.WIDTH(4), .DESCENDING(1'b1)) dut_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
      .out_valid(out_valid_d), .out_data(out_data_d), .out_last(out_last_d),
      .out_ready(out_ready), .count(count_d)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_grp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
      grp[0] = a; grp[1] = b; grp[2] = c; grp[3] = d;
   endtask

   task automatic set_rand_grp();
      for (int i = 0; i < 4; i++) grp[i] = 4'($urandom_range(0, 15));
   endtask

   // Reference: plain sort of the group's values
   task automatic build_expect();
      q_asc = {};
      for (int i = 0; i < 4; i++) q_asc.push_back(int'(grp[i]));
      q_desc = q_asc;
      q_asc.sort();
      q_desc.rsort();
   endtask

   // Offer the four values; optional idle gaps; optionally keep in_valid high afterwards
   task automatic load_group(input bit gapped, input bit hold_valid);
      for (int i = 0; i < 4; i++) begin
         bit accepted = 1'b0;
         int t = 0;
         if (gapped) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = grp[i];
         while (!accepted && t < 20) begin
            @(negedge clk);
            chk("load_count_a", 32'(count_a), i);
            chk("load_count_d", 32'(count_d), i);
            chk("load_in_ready_d", 32'(in_ready_d), 32'(in_ready_a));
            if (in_ready_a) accepted = 1'b1;
            @(posedge clk); #1;
            t++;
         end
         if (!accepted) chk("accept_timeout", 0, 1);
      end
      if (hold_valid) in_data = 4'($urandom_range(0, 15));
      else in_valid = 1'b0;
   endtask

   // Mode 0: always ready, 1: toggle ready, 2: random ready. Stops after n_out handshakes.
   task automatic drain_group(input int mode, input int n_out);
      int   n = 0;
      int   t = 0;
      bit   tog = 1'b0;
      bit   held = 1'b0;
      logic [3:0] hold_a = '0;
      logic [3:0] hold_d = '0;
      build_expect();
      while (n < n_out && t < 60) begin
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         @(negedge clk);
         if (t == 0) chk("first_valid_latency", 32'(out_valid_a), 1);
         chk("drain_valid_a", 32'(out_valid_a), 1);
         chk("drain_valid_d", 32'(out_valid_d), 1);
         chk("drain_in_ready", 32'(in_ready_a), 0);
         if (held) begin
            chk("hold_data_a", 32'(out_data_a), 32'(hold_a));
            chk("hold_data_d", 32'(out_data_d), 32'(hold_d));
         end
         chk("data_asc", 32'(out_data_a), q_asc[n]);
         chk("data_desc", 32'(out_data_d), q_desc[n]);
         chk("last_a", 32'(out_last_a), (n == 3) ? 1 : 0);
         chk("last_d", 32'(out_last_d), (n == 3) ? 1 : 0);
         chk("drain_count", 32'(count_a), 4 - n);
         if (out_ready) begin
            n++;
            held = 1'b0;
         end else begin
            held   = 1'b1;
            hold_a = out_data_a;
            hold_d = out_data_d;
         end
         @(posedge clk); #1;
         t++;
      end
      if (n < n_out) chk("drain_timeout", 32'(n), 32'(n_out));
      if (mode == 0) chk("drain_cycles", 32'(t), 32'(n_out));
      if (n_out == 4) begin
         in_valid  = 1'b0;
         out_ready = 1'b0;
         @(negedge clk);
         chk("post_valid", 32'(out_valid_a), 0);
         chk("post_count", 32'(count_a), 0);
         chk("post_in_ready", 32'(in_ready_a), 1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready_a), 0);
      chk("rst_out_valid", 32'(out_valid_a), 0);
      chk("rst_out_last", 32'(out_last_a), 0);
      chk("rst_out_data", 32'(out_data_a), 0);
      chk("rst_count", 32'(count_a), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back load, full-rate drain
      set_grp(4'b1111, 4'b0010, 4'b0001, 4'b0000);
      load_group(1'b0, 1'b0);
      drain_group(0, 4);

      // Same group under alternating backpressure
      load_group(1'b0, 1'b0);
      drain_group(1, 4);

      // Duplicates
      set_grp(4'b0101, 4'b0011, 4'b0101, 4'b0011);
      load_group(1'b0, 1'b0);
      drain_group(0, 4);

      // Descending-oriented group with tied maxima
      set_grp(4'b0000, 4'b1001, 4'b0100, 4'b1001);
      load_group(1'b0, 1'b0);
      drain_group(0, 4);

      // Asynchronous reset mid-drain
      set_grp(4'b1100, 4'b0110, 4'b1010, 4'b0001);
      load_group(1'b0, 1'b0);
      drain_group(0, 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid_a", 32'(out_valid_a), 0);
      chk("mid_rst_valid_d", 32'(out_valid_d), 0);
      chk("mid_rst_count", 32'(count_a), 0);
      chk("mid_rst_last", 32'(out_last_a), 0);
      chk("mid_rst_in_ready", 32'(in_ready_a), 0);
      @(posedge clk); #3;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready_a), 1);
      chk("post_rst_count", 32'(count_a), 0);
      @(posedge clk); #1;
      set_grp(4'b0111, 4'b0001, 4'b0011, 4'b0010);
      load_group(1'b0, 1'b0);
      drain_group(0, 4);

      // Random groups: gapped input, in_valid held through drain, random backpressure
      for (int g = 0; g < 24; g++) begin
         set_rand_grp();
         load_group(1'b1, g[0]);
         drain_group((g % 3 == 0) ? 1 : 2, 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
